// File: rtl/point_stream_pkg.sv
// Shared types and constants for the point stream writer.
package point_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CKSUM,
        WAIT,
        WRITE
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hFF;
    localparam int SRAM_W = 16;

    function automatic longint last_addr(
        input longint base,
        input longint max_points,
        input longint words_per_point
    );
        return base + max_points * words_per_point - 1;
    endfunction

endpackage

// File: rtl/point_stream_writer_strobe.sv
// Rising-edge detector on UART byte-valid; ignores a DV held high out of reset.
module rx_byte_strobe (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_valid,
    output logic [7:0] o_byte
);

    logic r_dv;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_dv <= 1'b1;
        else          r_dv <= i_Rx_DV;
    end

    assign o_valid = i_Rx_DV & ~r_dv;
    assign o_byte  = i_Rx_Byte;

endmodule

// File: rtl/point_stream_writer.sv
// Frames sync+payload UART packets into 16-bit SRAM words at consecutive addresses.
// Optional trailing XOR checksum byte enabled by defining RX_CHECKSUM_EN.
module point_stream_writer
    import point_stream_pkg::*;
#(
    parameter int         WORDS_PER_POINT = 3,
    parameter int         ADDR_W          = 20,
    parameter int         BASE_ADDR       = 0,
    parameter int         MAX_POINTS      = 349525,
    parameter int         CNT_W           = 21,
    parameter logic [7:0] SYNC_BYTE       = SYNC_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_write_grant,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic [CNT_W-1:0]  o_point_count,
    output logic              o_full,
    output logic              o_overrun,
    output logic              o_cksum_err,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [15:0]       io_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);

    localparam int NB  = 2 * WORDS_PER_POINT;
    localparam int SRW = SRAM_W * WORDS_PER_POINT;
    localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] A_LAST =
        ADDR_W'(last_addr(BASE_ADDR, MAX_POINTS, WORDS_PER_POINT));
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_POINTS);
    localparam logic [4:0]       B_LAST = 5'(NB - 1);
    localparam logic [2:0]       K_LAST = 3'(WORDS_PER_POINT - 1);

    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [SRW-1:0]     r_sr;
    logic [4:0]         r_bcnt;
    logic [2:0]         r_k;
    logic [CNT_W-1:0]   r_count;
    logic               r_overrun;
    logic               w_acc;
    logic [7:0]         w_byte;
    logic               w_full;
    logic               w_we;

    rx_byte_strobe u_strobe (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_Rx_DV   (i_Rx_DV),
        .i_Rx_Byte (i_Rx_Byte),
        .o_valid   (w_acc),
        .o_byte    (w_byte)
    );

    assign w_full = (r_count == C_MAX);
    assign w_we   = (r_state == WRITE) && i_write_grant;

`ifdef RX_CHECKSUM_EN
    logic [7:0] r_x;
    logic       r_cksum_err;
    logic       w_ck_ok;

    assign w_ck_ok = (w_byte == r_x);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x         <= 8'h00;
            r_cksum_err <= 1'b0;
        end else if (i_clear) begin
            r_x         <= 8'h00;
            r_cksum_err <= 1'b0;
        end else if (w_acc) begin
            if (r_state == IDLE)
                r_x <= 8'h00;
            else if (r_state == RECV)
                r_x <= r_x ^ w_byte;
            else if (r_state == CKSUM && !w_ck_ok)
                r_cksum_err <= 1'b1;
        end
    end

    assign o_cksum_err = r_cksum_err;
`else
    assign o_cksum_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:
                if (w_acc && w_byte == SYNC_BYTE) w_next = RECV;
            RECV:
                if (w_acc && r_bcnt == B_LAST) begin
`ifdef RX_CHECKSUM_EN
                    w_next = CKSUM;
`else
                    w_next = WAIT;
`endif
                end
            CKSUM: begin
`ifdef RX_CHECKSUM_EN
                if (w_acc) w_next = w_ck_ok ? WAIT : IDLE;
`else
                w_next = IDLE;
`endif
            end
            WAIT:
                if (w_full)             w_next = IDLE;
                else if (i_write_grant) w_next = WRITE;
            WRITE:
                if (i_write_grant && r_k == K_LAST) w_next = IDLE;
            default:
                w_next = IDLE;
        endcase
        if (i_clear) w_next = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr    <= A_BASE;
            r_sr      <= '0;
            r_bcnt    <= '0;
            r_k       <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else if (i_clear) begin
            r_addr    <= A_BASE;
            r_sr      <= '0;
            r_bcnt    <= '0;
            r_k       <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                IDLE:
                    if (w_acc && w_byte == SYNC_BYTE) begin
                        r_bcnt <= '0;
                        r_sr   <= '0;
                    end
                RECV:
                    if (w_acc) begin
                        r_sr   <= {r_sr[SRW-9:0], w_byte};
                        r_bcnt <= r_bcnt + 5'd1;
                    end
                WAIT:
                    if (w_acc) r_overrun <= 1'b1;
                WRITE: begin
                    if (w_acc) r_overrun <= 1'b1;
                    if (i_write_grant) begin
                        // Saturate at the last word so a full buffer never wraps.
                        r_addr <= (r_addr == A_LAST) ? r_addr : r_addr + 1'b1;
                        if (r_k == K_LAST) begin
                            r_k     <= '0;
                            r_count <= r_count + 1'b1;
                        end else begin
                            r_k <= r_k + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_point_count = r_count;
    assign o_full        = w_full;
    assign o_overrun     = r_overrun;
    assign o_SRAM_ADDR   = r_addr;
    assign o_SRAM_WE_N   = ~w_we;
    assign o_SRAM_OE_N   = (r_state == WRITE);
    assign o_SRAM_CE_N   = 1'b0;
    assign o_SRAM_LB_N   = 1'b0;
    assign o_SRAM_UB_N   = 1'b0;
    assign io_SRAM_DQ    = w_we ? r_sr[SRAM_W*int'(r_k) +: SRAM_W] : 16'bz;

endmodule

// File: tb/tb_point_stream_writer.sv
// Randomised directed bench for point_stream_writer with a packet-level SRAM model.
module tb_point_stream_writer;

    localparam int W    = 3;
    localparam int NB   = 2 * W;
    localparam int AW   = 20;
    localparam int BASE = 16;
    localparam int MAXP = 3;
    localparam int CW   = 21;

    logic          clk = 1'b0;
    logic          rst_n, clear, grant, dv;
    logic [7:0]    rxb;
    wire  [15:0]   dq;
    logic [CW-1:0] cnt;
    logic          full, ovr, ckerr;
    logic [AW-1:0] addr;
    logic          we_n, ce_n, oe_n, lb_n, ub_n;

    always #5 clk = ~clk;

    point_stream_writer #(
        .WORDS_PER_POINT (W),
        .ADDR_W          (AW),
        .BASE_ADDR       (BASE),
        .MAX_POINTS      (MAXP),
        .CNT_W           (CW),
        .SYNC_BYTE       (8'hFF)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_clear       (clear),
        .i_write_grant (grant),
        .i_Rx_DV       (dv),
        .i_Rx_Byte     (rxb),
        .o_point_count (cnt),
        .o_full        (full),
        .o_overrun     (ovr),
        .o_cksum_err   (ckerr),
        .o_SRAM_ADDR   (addr),
        .io_SRAM_DQ    (dq),
        .o_SRAM_WE_N   (we_n),
        .o_SRAM_CE_N   (ce_n),
        .o_SRAM_OE_N   (oe_n),
        .o_SRAM_LB_N   (lb_n),
        .o_SRAM_UB_N   (ub_n)
    );

    int          checks = 0;
    int          errors = 0;
    logic [35:0] wq[$];
    logic [7:0]  pl[NB];

    // Every cycle with WE_N low is one SRAM word write.
    always @(negedge clk)
        if (rst_n === 1'b1 && we_n === 1'b0)
            wq.push_back({16'(addr), dq});

    task automatic chk(input string tag, input logic [35:0] obs,
                       input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        rxb = b;
        dv  = 1'b1;
        cyc(hold);
        dv  = 1'b0;
        cyc(1 + int'($urandom % 2));
    endtask

    task automatic rand_pl();
        for (int i = 0; i < NB; i++) pl[i] = 8'($urandom);
    endtask

    // hold == 0 picks a random DV high time per byte.
    task automatic send_pkt(input int hold, input bit bad_ck);
        logic [7:0] x;
        x = 8'h00;
        send_byte(8'hFF, hold == 0 ? int'($urandom_range(1, 4)) : hold);
        for (int i = 0; i < NB; i++) begin
            x ^= pl[i];
            send_byte(pl[i], hold == 0 ? int'($urandom_range(1, 4)) : hold);
        end
`ifdef RX_CHECKSUM_EN
        send_byte(bad_ck ? ~x : x, 1);
`else
        if (bad_ck) x = 8'h00;
`endif
    endtask

    task automatic wait_count(input int target, input bit rnd_grant);
        for (int i = 0; i < 100 && cnt !== CW'(target); i++) begin
            if (rnd_grant) grant = 1'($urandom % 2);
            cyc(1);
        end
        grant = 1'b1;
        chk("count", 36'(cnt), 36'(target));
    endtask

    task automatic check_pt(input int pt);
        logic [35:0] e;
        chk("nwrites", 36'(wq.size()), 36'(W));
        for (int k = 0; k < W; k++) begin
            e = {16'(BASE + pt * W + k), pl[NB-2-2*k], pl[NB-1-2*k]};
            if (k < wq.size()) chk("word", wq[k], e);
        end
        wq.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        grant = 1'b1;
        dv    = 1'b1;
        rxb   = 8'hFF;
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        dv = 1'b0;
        cyc(2);

        chk("rst_count", 36'(cnt), 36'd0);
        chk("rst_full", 36'(full), 36'd0);
        chk("rst_ovr", 36'(ovr), 36'd0);
        chk("rst_ckerr", 36'(ckerr), 36'd0);
        chk("rst_we_n", 36'(we_n), 36'd1);
        chk("rst_oe_n", 36'(oe_n), 36'd0);
        chk("rst_addr", 36'(addr), 36'(BASE));
        chk("rst_ctl", 36'({ce_n, lb_n, ub_n}), 36'd0);

        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_pkt(1, 1'b0);
        wait_count(1, 1'b0);
        check_pt(0);

        pl = '{8'hFF, 8'h22, 8'hFF, 8'h44, 8'h55, 8'hFF};
        send_pkt(4, 1'b0);
        wait_count(2, 1'b0);
        check_pt(1);

        grant = 1'b0;
        rand_pl();
        send_pkt(0, 1'b0);
        cyc(4);
        chk("stall_nwrites", 36'(wq.size()), 36'd0);
        chk("stall_ovr0", 36'(ovr), 36'd0);
        send_byte(8'h77, 1);
        chk("ovr_set", 36'(ovr), 36'd1);
        chk("ovr_nwrites", 36'(wq.size()), 36'd0);
        grant = 1'b1;
        wait_count(3, 1'b0);
        check_pt(2);
        chk("full_set", 36'(full), 36'd1);

        rand_pl();
        send_pkt(0, 1'b0);
        cyc(10);
        chk("full_nwrites", 36'(wq.size()), 36'd0);
        chk("full_count", 36'(cnt), 36'(MAXP));

        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("clr_count", 36'(cnt), 36'd0);
        chk("clr_full", 36'(full), 36'd0);
        chk("clr_ovr", 36'(ovr), 36'd0);
        chk("clr_addr", 36'(addr), 36'(BASE));

        rand_pl();
        send_pkt(1, 1'b0);
        wait_count(1, 1'b0);
        check_pt(0);

        rand_pl();
        send_pkt(1, 1'b0);
        for (int i = 0; i < 40 && wq.size() < 2; i++) begin
            @(negedge clk);
            #1;
        end
        chk("abort_sync", 36'(wq.size()), 36'd2);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        wq.delete();
        chk("abort_count", 36'(cnt), 36'd0);
        chk("abort_addr", 36'(addr), 36'(BASE));
        chk("abort_we_n", 36'(we_n), 36'd1);
        rand_pl();
        send_pkt(0, 1'b0);
        wait_count(1, 1'b0);
        check_pt(0);

        for (int p = 1; p < MAXP; p++) begin
            rand_pl();
            send_pkt(0, 1'b0);
            wait_count(p + 1, 1'b1);
            check_pt(p);
        end
        chk("rand_full", 36'(full), 36'd1);

        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_pkt(1, 1'b0);
        wait_count(1, 1'b0);
        check_pt(0);
`ifdef RX_CHECKSUM_EN
        send_pkt(1, 1'b1);
        cyc(10);
        chk("ck_err", 36'(ckerr), 36'd1);
        chk("ck_nwrites", 36'(wq.size()), 36'd0);
        chk("ck_count", 36'(cnt), 36'd1);
`else
        chk("ck_tied", 36'(ckerr), 36'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
